dice_roll_ctrl: RTL and testbench



---
 rtl/dice_pkg.sv | 23 ++
 rtl/dice_roll_ctrl_counter.sv | 32 +++
 rtl/dice_roll_ctrl.sv | 142 ++++++++++++++
 tb/tb_dice_roll_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice game roll controller.
package dice_pkg;

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_POINT = 2'd1,
        S_WIN   = 2'd2,
        S_LOSE  = 2'd3
    } state_e;

    localparam logic [2:0] DIE_MAX    = 3'd6;
    localparam logic [3:0] NATURAL_7  = 4'd7;
    localparam logic [3:0] NATURAL_11 = 4'd11;
    localparam logic [3:0] CRAPS_2    = 4'd2;
    localparam logic [3:0] CRAPS_3    = 4'd3;
    localparam logic [3:0] CRAPS_12   = 4'd12;
    localparam logic [3:0] SEVEN_OUT  = 4'd7;

    function automatic logic is_rolling(input state_e s);
        return (s == S_FIRST) || (s == S_POINT);
    endfunction

endpackage

// File: rtl/dice_roll_ctrl_counter.sv
// One die: a 1..6 modulo counter whose wrap output carries into the next die.
module dice_counter
    import dice_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] val,
    output logic       wrap
);

    logic [2:0] val_q, val_d;

    always_comb begin
        wrap  = en && (val_q == DIE_MAX);
        val_d = val_q;
        if (en) begin
            val_d = (val_q == DIE_MAX) ? 3'd1 : val_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= 3'd1;
        end else begin
            val_q <= val_d;
        end
    end

    assign val = val_q;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roller and craps rule FSM feeding the two-digit display decoder.
// Optional roll counter output enabled by defining DICE_ROLL_COUNT_EN.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int unsigned ROLL_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_btn,
    input  logic       new_game,
    output logic [2:0] die1,
    output logic [2:0] die2,
    output logic [3:0] sum,
    output logic [3:0] point,
    output logic       win,
    output logic       lose
`ifdef DICE_ROLL_COUNT_EN
    ,
    output logic [3:0] roll_count
`endif
);

    localparam logic [7:0] DIV_LAST = 8'(ROLL_DIV - 1);

    logic       btn_q;
    logic [7:0] pre_q, pre_d;
    state_e     state_q, state_d;
    logic [3:0] sum_q, sum_d;
    logic [3:0] point_q, point_d;
    logic       win_q, win_d;
    logic       lose_q, lose_d;
    logic       adv, rel, accept;
    logic       d1_wrap, die2_wrap_unused;
    logic [3:0] roll_sum;

    dice_counter u_die1 (
        .clk  (clk),
        .rst  (rst),
        .en   (adv),
        .val  (die1),
        .wrap (d1_wrap)
    );

    dice_counter u_die2 (
        .clk  (clk),
        .rst  (rst),
        .en   (d1_wrap),
        .val  (die2),
        .wrap (die2_wrap_unused)
    );

    assign roll_sum = {1'b0, die1} + {1'b0, die2};

    always_comb begin
        pre_d   = roll_btn ? ((pre_q == DIV_LAST) ? 8'd0 : pre_q + 8'd1) : 8'd0;
        adv     = roll_btn && (pre_q == DIV_LAST) && is_rolling(state_q);
        rel     = btn_q && !roll_btn;
        accept  = rel && is_rolling(state_q) && !new_game;
        state_d = state_q;
        sum_d   = sum_q;
        point_d = point_q;
        if (new_game) begin
            state_d = S_FIRST;
            point_d = 4'd0;
        end else if (accept) begin
            sum_d = roll_sum;
            unique case (state_q)
                S_FIRST: begin
                    if (roll_sum == NATURAL_7 || roll_sum == NATURAL_11) begin
                        state_d = S_WIN;
                    end else if (roll_sum == CRAPS_2 || roll_sum == CRAPS_3 ||
                                 roll_sum == CRAPS_12) begin
                        state_d = S_LOSE;
                    end else begin
                        point_d = roll_sum;
                        state_d = S_POINT;
                    end
                end
                S_POINT: begin
                    if (roll_sum == point_q) begin
                        state_d = S_WIN;
                    end else if (roll_sum == SEVEN_OUT) begin
                        state_d = S_LOSE;
                    end
                end
                default: ;
            endcase
        end
        win_d  = (state_d == S_WIN);
        lose_d = (state_d == S_LOSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q   <= 1'b0;
            pre_q   <= 8'd0;
            state_q <= S_FIRST;
            sum_q   <= 4'd0;
            point_q <= 4'd0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            btn_q   <= roll_btn;
            pre_q   <= pre_d;
            state_q <= state_d;
            sum_q   <= sum_d;
            point_q <= point_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    assign sum   = sum_q;
    assign point = point_q;
    assign win   = win_q;
    assign lose  = lose_q;

`ifdef DICE_ROLL_COUNT_EN
    logic [3:0] rc_q, rc_d;

    always_comb begin
        rc_d = rc_q;
        if (new_game) begin
            rc_d = 4'd0;
        end else if (accept && rc_q != 4'd15) begin
            rc_d = rc_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_q <= 4'd0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign roll_count = rc_q;
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: directed table on ROLL_DIV=1, random vs model on both instances.
module tb_dice_roll_ctrl;

    localparam int M_FIRST = 0;
    localparam int M_POINT = 1;
    localparam int M_WIN   = 2;
    localparam int M_LOSE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    logic ng  = 1'b0;

    logic [2:0] d1_a, d2_a, d1_b, d2_b;
    logic [3:0] s_a, p_a, s_b, p_b;
    logic       w_a, l_a, w_b, l_b;
`ifdef DICE_ROLL_COUNT_EN
    logic [3:0] rc_a, rc_b;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dice_roll_ctrl #(.ROLL_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .roll_btn(btn), .new_game(ng),
        .die1(d1_a), .die2(d2_a), .sum(s_a), .point(p_a),
        .win(w_a), .lose(l_a)
`ifdef DICE_ROLL_COUNT_EN
        , .roll_count(rc_a)
`endif
    );

    dice_roll_ctrl #(.ROLL_DIV(3)) dut_b (
        .clk(clk), .rst(rst), .roll_btn(btn), .new_game(ng),
        .die1(d1_b), .die2(d2_b), .sum(s_b), .point(p_b),
        .win(w_b), .lose(l_b)
`ifdef DICE_ROLL_COUNT_EN
        , .roll_count(rc_b)
`endif
    );

    // Reference model: total advances n gives die1 = n%6+1, die2 = (n/6)%6+1.
    int divs[2] = '{1, 3};
    int m_n[2], m_pre[2], m_st[2], m_sum[2], m_pt[2], m_rc[2];
    bit m_btnq;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_pre[i] = 0; m_st[i] = M_FIRST;
            m_sum[i] = 0; m_pt[i] = 0; m_rc[i] = 0;
        end
        m_btnq = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit rolling;
            int s;
            rolling = (m_st[i] == M_FIRST) || (m_st[i] == M_POINT);
            s = (m_n[i] % 6 + 1) + ((m_n[i] / 6) % 6 + 1);
            if (btn && m_pre[i] == divs[i] - 1 && rolling) m_n[i]++;
            if (ng) begin
                m_st[i] = M_FIRST; m_pt[i] = 0; m_rc[i] = 0;
            end else if (m_btnq && !btn && rolling) begin
                m_sum[i] = s;
                if (m_rc[i] < 15) m_rc[i]++;
                if (m_st[i] == M_FIRST) begin
                    if (s == 7 || s == 11) m_st[i] = M_WIN;
                    else if (s == 2 || s == 3 || s == 12) m_st[i] = M_LOSE;
                    else begin m_pt[i] = s; m_st[i] = M_POINT; end
                end else begin
                    if (s == m_pt[i]) m_st[i] = M_WIN;
                    else if (s == 7) m_st[i] = M_LOSE;
                end
            end
            if (btn) m_pre[i] = (m_pre[i] == divs[i] - 1) ? 0 : m_pre[i] + 1;
            else m_pre[i] = 0;
        end
        m_btnq = btn;
    endtask

    task automatic chk(input string nm, input int idx, input int d1, input int d2,
                       input int s, input int p, input bit w, input bit l);
        logic [15:0] got, exp;
        if (idx == 0) got = {d1_a, d2_a, s_a, p_a, w_a, l_a};
        else          got = {d1_b, d2_b, s_b, p_b, w_b, l_b};
        exp = {3'(d1), 3'(d2), 4'(s), 4'(p), w, l};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got d1=%0d d2=%0d sum=%0d pt=%0d w=%0b l=%0b, exp d1=%0d d2=%0d sum=%0d pt=%0d w=%0b l=%0b",
                     nm, idx, got[15:13], got[12:10], got[9:6], got[5:2], got[1], got[0],
                     d1, d2, s, p, w, l);
        end
    endtask

    task automatic chk_model(input string nm, input int idx);
        chk(nm, idx, m_n[idx] % 6 + 1, (m_n[idx] / 6) % 6 + 1, m_sum[idx], m_pt[idx],
            m_st[idx] == M_WIN, m_st[idx] == M_LOSE);
`ifdef DICE_ROLL_COUNT_EN
        begin
            logic [3:0] rc;
            rc = (idx == 0) ? rc_a : rc_b;
            nvec++;
            if (rc !== 4'(m_rc[idx])) begin
                nerr++;
                $display("FAIL %s_rc dut%0d: got %0d exp %0d", nm, idx, rc, m_rc[idx]);
            end
        end
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk_model("model_b", 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("reset", 0, 1, 1, 0, 0, 0, 0);
        chk_model("reset_b", 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic       r;
        logic       b;
        logic       n;
        logic [7:0] cyc;
        logic [2:0] d1;
        logic [2:0] d2;
        logic [3:0] s;
        logic [3:0] p;
        logic       w;
        logic       l;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit b, bit n, int cyc, int d1, int d2,
                                int s, int p, bit w, bit l);
        vec_t v;
        v = {r, b, n, 8'(cyc), 3'(d1), 3'(d2), 4'(s), 4'(p), w, l};
        return v;
    endfunction

    initial begin
        // natural win, new game, point 8 made
        tbl.push_back(mk(1, 1, 0, 5, 6, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 1, 7, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 3, 6, 1, 7, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 6, 1, 7, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 6, 6, 2, 7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 2, 8, 8, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 3, 8, 8, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 3, 4, 8, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4, 5, 3, 4, 8, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 3, 8, 8, 1, 0));
        // craps, then dice frozen
        tbl.push_back(mk(1, 1, 0, 6, 1, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 3, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 4, 1, 2, 3, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 3, 0, 0, 1));
        // point 5 then seven-out
        tbl.push_back(mk(1, 1, 0, 3, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 1, 5, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 6, 1, 5, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 1, 7, 5, 0, 1));
        // point 5 matched after several sixes
        tbl.push_back(mk(1, 1, 0, 3, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 1, 5, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 6, 4, 2, 5, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 2, 6, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5, 3, 3, 6, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 3, 6, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5, 2, 4, 6, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 4, 6, 5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 35, 1, 4, 6, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4, 5, 5, 1, 0));
        // new_game together with release discards the roll
        tbl.push_back(mk(1, 1, 0, 3, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 6, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 1, 7, 0, 1, 0));

        @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            vec_t v;
            v = tbl[k];
            if (v.r) begin
                btn = v.b;
                do_reset();
            end
            btn = v.b;
            ng  = v.n;
            for (int c = 0; c < int'(v.cyc); c++) begin
                tick();
                ng = 1'b0;
            end
            chk($sformatf("tbl%0d", k), 0, v.d1, v.d2, v.s, v.p, v.w, v.l);
        end

        // mid-roll reset with the button still held
        btn = 1'b1;
        repeat (4) tick();
        do_reset();
        repeat (2) tick();
        chk("resume_a", 0, 3, 1, 0, 0, 0, 0);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) btn = ~btn;
            ng = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 600) == 0) do_reset();
            tick();
            chk_model("model_a", 0);
        end
        ng = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
